// File: rtl/readout_arbiter.sv
// Grants the shared row-decoder/column-ADC path to one of two readout engines,
// issues its start trigger, tracks its busy handshake and enforces a guard gap.
module readout_arbiter #(
  parameter int TRIG_LEN     = 2,
  parameter int BUSY_TIMEOUT = 64,
  parameter int CNT_W        = 16
) (
  input  logic             TX_CLK,
  input  logic             rst_n,
  input  logic             en,
  input  logic             prio_mode,
  input  logic [31:0]      T_gap,
  input  logic             req1,
  input  logic             req2,
  input  logic             adc1_busy,
  input  logic             adc2_busy,
  input  logic             clr_err,
  output logic             adc1_start_trigger,
  output logic             adc2_start_trigger,
  output logic [1:0]       active_sel,
  output logic             sched_busy,
  output logic             pend1,
  output logic             pend2,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic             err_timeout,
  output logic             err_conflict,
  output logic             err_ovf
);

  localparam int TO_W = $clog2(BUSY_TIMEOUT + TRIG_LEN + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_WAIT_FALL,
    S_GAP
  } state_e;

  state_e           state_q;
  logic             trig1_q, trig2_q;
  logic [1:0]       sel_q;
  logic             last2_q;
  logic             pend1_q, pend2_q;
  logic [3:0]       trig_cnt_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic [31:0]      gap_cnt_q;
  logic [CNT_W-1:0] cnt1_q, cnt2_q;
  logic             err_timeout_q, err_conflict_q, err_ovf_q;

  logic grant, win2, clr1, clr2;
  logic own_busy, other_busy;
  logic timeout_evt, conflict_evt, ovf_evt;
  logic pend1_d, pend2_d;
  logic err_timeout_d, err_conflict_d, err_ovf_d;

  // Round-robin favours the engine not granted last; fixed mode always favours ADC2.
  assign grant = (state_q == S_IDLE) && en && (pend1_q || pend2_q);
  assign win2  = pend2_q && (!pend1_q || prio_mode || !last2_q);
  assign clr1  = grant && !win2;
  assign clr2  = grant && win2;

  // A request landing on the cycle its flag is consumed is a fresh request, not an overflow.
  assign pend1_d = (pend1_q && !clr1) || req1;
  assign pend2_d = (pend2_q && !clr2) || req2;
  assign ovf_evt = (req1 && pend1_q && !clr1) || (req2 && pend2_q && !clr2);

  assign own_busy     = sel_q[1] ? adc2_busy : adc1_busy;
  assign other_busy   = sel_q[1] ? adc1_busy : adc2_busy;
  assign conflict_evt = (state_q == S_IDLE) ? (adc1_busy || adc2_busy) : other_busy;
  assign timeout_evt  = (state_q == S_WAIT_RISE) && !own_busy &&
                        (to_cnt_q >= TO_W'(BUSY_TIMEOUT));

  // Error events outrank a simultaneous clear so no event is ever lost.
  assign err_timeout_d  = (err_timeout_q  && !clr_err) || timeout_evt;
  assign err_conflict_d = (err_conflict_q && !clr_err) || conflict_evt;
  assign err_ovf_d      = (err_ovf_q      && !clr_err) || ovf_evt;

  always_ff @(posedge TX_CLK) begin
    // NOTE: reset is synchronous, so it is tested inside the clocked block, not in the sensitivity list.
    if (!rst_n) begin
      state_q        <= S_IDLE;
      trig1_q        <= 1'b0;
      trig2_q        <= 1'b0;
      sel_q          <= 2'b00;
      last2_q        <= 1'b1;
      pend1_q        <= 1'b0;
      pend2_q        <= 1'b0;
      trig_cnt_q     <= 4'd0;
      to_cnt_q       <= '0;
      gap_cnt_q      <= 32'd0;
      cnt1_q         <= '0;
      cnt2_q         <= '0;
      err_timeout_q  <= 1'b0;
      err_conflict_q <= 1'b0;
      err_ovf_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from the same pre-edge values.
      pend1_q        <= pend1_d;
      pend2_q        <= pend2_d;
      err_timeout_q  <= err_timeout_d;
      err_conflict_q <= err_conflict_d;
      err_ovf_q      <= err_ovf_d;

      unique case (state_q)
        S_IDLE: begin
          if (grant) begin
            state_q    <= S_TRIG;
            sel_q      <= win2 ? 2'b10 : 2'b01;
            trig1_q    <= !win2;
            trig2_q    <= win2;
            last2_q    <= win2;
            trig_cnt_q <= 4'(TRIG_LEN - 1);
            to_cnt_q   <= TO_W'(1);
          end
        end
        S_TRIG: begin
          to_cnt_q <= to_cnt_q + TO_W'(1);
          if (trig_cnt_q == 4'd0) begin
            trig1_q <= 1'b0;
            trig2_q <= 1'b0;
            state_q <= own_busy ? S_WAIT_FALL : S_WAIT_RISE;
          end else begin
            trig_cnt_q <= trig_cnt_q - 4'd1;
          end
        end
        S_WAIT_RISE: begin
          to_cnt_q <= to_cnt_q + TO_W'(1);
          if (own_busy) begin
            state_q <= S_WAIT_FALL;
          end else if (timeout_evt) begin
            state_q   <= S_GAP;
            gap_cnt_q <= T_gap;
          end
        end
        S_WAIT_FALL: begin
          if (!own_busy) begin
            state_q   <= S_GAP;
            gap_cnt_q <= T_gap;
            if (sel_q[1]) cnt2_q <= cnt2_q + CNT_W'(1);
            else          cnt1_q <= cnt1_q + CNT_W'(1);
          end
        end
        S_GAP: begin
          // Gap lasts T_gap cycles; a zero gap still spends one cycle here.
          if (gap_cnt_q <= 32'd1) begin
            state_q <= S_IDLE;
            sel_q   <= 2'b00;
          end else begin
            gap_cnt_q <= gap_cnt_q - 32'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign adc1_start_trigger = trig1_q;
  assign adc2_start_trigger = trig2_q;
  assign active_sel         = sel_q;
  assign sched_busy         = (state_q != S_IDLE);
  assign pend1              = pend1_q;
  assign pend2              = pend2_q;
  assign cnt1               = cnt1_q;
  assign cnt2               = cnt2_q;
  assign err_timeout        = err_timeout_q;
  assign err_conflict       = err_conflict_q;
  assign err_ovf            = err_ovf_q;

endmodule

// File: tb/tb_readout_arbiter.sv
// Directed bench for readout_arbiter: behavioural engine models plus one task per scenario.
module tb_readout_arbiter;

  logic        TX_CLK = 1'b0;
  logic        rst_n, en, prio_mode, req1, req2, clr_err;
  logic [31:0] T_gap;
  logic        busy1_model, busy1_force, busy2_model;
  logic        adc1_busy, adc2_busy;
  logic        adc1_start_trigger, adc2_start_trigger;
  logic [1:0]  active_sel;
  logic        sched_busy, pend1, pend2;
  logic [15:0] cnt1, cnt2;
  logic        err_timeout, err_conflict, err_ovf;

  int total = 0;
  int bad   = 0;

  always #5 TX_CLK = ~TX_CLK;

  assign adc1_busy = busy1_model | busy1_force;
  assign adc2_busy = busy2_model;

  readout_arbiter dut (
    .TX_CLK(TX_CLK), .rst_n(rst_n), .en(en), .prio_mode(prio_mode), .T_gap(T_gap),
    .req1(req1), .req2(req2), .adc1_busy(adc1_busy), .adc2_busy(adc2_busy),
    .clr_err(clr_err),
    .adc1_start_trigger(adc1_start_trigger), .adc2_start_trigger(adc2_start_trigger),
    .active_sel(active_sel), .sched_busy(sched_busy), .pend1(pend1), .pend2(pend2),
    .cnt1(cnt1), .cnt2(cnt2),
    .err_timeout(err_timeout), .err_conflict(err_conflict), .err_ovf(err_ovf)
  );

  // Grant log and protocol watchers, sampled mid-cycle.
  int grants[$];
  int overlap_err = 0;
  int len_err     = 0;
  int run1 = 0, run2 = 0;

  always @(negedge TX_CLK) begin
    if (!rst_n) begin
      run1 = 0;
      run2 = 0;
    end else begin
      if (adc1_start_trigger && adc2_start_trigger) overlap_err++;
      if (active_sel == 2'b11) overlap_err++;
      if (adc1_start_trigger) begin
        if (run1 == 0) grants.push_back(1);
        run1++;
      end else begin
        if (run1 != 0 && run1 != 2) len_err++;
        run1 = 0;
      end
      if (adc2_start_trigger) begin
        if (run2 == 0) grants.push_back(2);
        run2++;
      end else begin
        if (run2 != 0 && run2 != 2) len_err++;
        run2 = 0;
      end
    end
  end

  // Engine models: busy rises e_delay cycles after the trigger edge and lasts e_len cycles.
  bit   eng1_on = 1'b1, eng2_on = 1'b1;
  int   e1_delay = 2, e1_len = 5, e1_dcnt = 0, e1_lcnt = 0;
  int   e2_delay = 2, e2_len = 5, e2_dcnt = 0, e2_lcnt = 0;
  logic e1_prev = 1'b0, e2_prev = 1'b0;

  initial begin
    busy1_model = 1'b0;
    forever begin
      @(posedge TX_CLK); #1;
      if (e1_dcnt > 0) begin
        e1_dcnt--;
        if (e1_dcnt == 0) begin busy1_model = 1'b1; e1_lcnt = e1_len; end
      end else if (busy1_model) begin
        e1_lcnt--;
        if (e1_lcnt == 0) busy1_model = 1'b0;
      end else if (eng1_on && adc1_start_trigger && !e1_prev) begin
        e1_dcnt = e1_delay;
      end
      e1_prev = adc1_start_trigger;
    end
  end

  initial begin
    busy2_model = 1'b0;
    forever begin
      @(posedge TX_CLK); #1;
      if (e2_dcnt > 0) begin
        e2_dcnt--;
        if (e2_dcnt == 0) begin busy2_model = 1'b1; e2_lcnt = e2_len; end
      end else if (busy2_model) begin
        e2_lcnt--;
        if (e2_lcnt == 0) busy2_model = 1'b0;
      end else if (eng2_on && adc2_start_trigger && !e2_prev) begin
        e2_dcnt = e2_delay;
      end
      e2_prev = adc2_start_trigger;
    end
  end

  task automatic tick();
    @(posedge TX_CLK); #1;
  endtask

  function automatic string q2s();
    string s = "";
    foreach (grants[i]) s = {s, $sformatf("%0d ", grants[i])};
    return s;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    grants.delete();
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while ((sched_busy || pend1 || pend2) && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (sched_busy || pend1 || pend2) begin
      bad++;
      $display("FAIL %s_idle: still busy after %0d cycles, expected idle", tag, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if ({adc1_start_trigger, adc2_start_trigger, active_sel, sched_busy} !== 5'b0) begin bad++; $display("FAIL reset_ctrl: got %b expected 00000", {adc1_start_trigger, adc2_start_trigger, active_sel, sched_busy}); end
    total++; if ({pend1, pend2} !== 2'b00) begin bad++; $display("FAIL reset_pend: got %b expected 00", {pend1, pend2}); end
    total++; if ({cnt1, cnt2} !== 32'd0) begin bad++; $display("FAIL reset_cnt: got %h expected 0", {cnt1, cnt2}); end
    total++; if ({err_timeout, err_conflict, err_ovf} !== 3'b000) begin bad++; $display("FAIL reset_err: got %b expected 000", {err_timeout, err_conflict, err_ovf}); end
  endtask

  task automatic test_single();
    e1_delay = 3; e1_len = 100; T_gap = 32'd10;
    req1 = 1'b1;
    tick();
    req1 = 1'b0;
    total++; if ({pend1, adc1_start_trigger} !== 2'b10) begin bad++; $display("FAIL single_capture: pend1/trig1 got %b expected 10", {pend1, adc1_start_trigger}); end
    tick();
    total++; if (adc1_start_trigger !== 1'b1) begin bad++; $display("FAIL single_trig_c0: got %b expected 1", adc1_start_trigger); end
    total++; if ({active_sel, pend1, sched_busy} !== 4'b0101) begin bad++; $display("FAIL single_grant: sel/pend1/busy got %b expected 0101", {active_sel, pend1, sched_busy}); end
    tick();
    total++; if (adc1_start_trigger !== 1'b1) begin bad++; $display("FAIL single_trig_c1: got %b expected 1", adc1_start_trigger); end
    tick();
    total++; if (adc1_start_trigger !== 1'b0) begin bad++; $display("FAIL single_trig_c2: got %b expected 0", adc1_start_trigger); end
    repeat (100) tick();
    total++; if ({sched_busy, cnt1} !== {1'b1, 16'd0}) begin bad++; $display("FAIL single_readout: busy=%b cnt1=%0d expected busy=1 cnt1=0", sched_busy, cnt1); end
    tick();
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 1) begin
        total++; if (cnt1 !== 16'd1) begin bad++; $display("FAIL single_cnt1: got %0d expected 1", cnt1); end
      end
      if (k == 10) begin
        total++; if (sched_busy !== 1'b1) begin bad++; $display("FAIL single_gap_end: sched_busy got %b expected 1", sched_busy); end
      end
      if (k == 11) begin
        total++; if ({sched_busy, active_sel} !== 3'b000) begin bad++; $display("FAIL single_idle: busy/sel got %b expected 000", {sched_busy, active_sel}); end
      end
    end
    total++; if (q2s() != "1 ") begin bad++; $display("FAIL single_grants: got '%s' expected '1 '", q2s()); end
  endtask

  task automatic test_enable();
    e1_delay = 2; e1_len = 5; T_gap = 32'd2;
    en = 1'b0;
    req1 = 1'b1;
    tick();
    req1 = 1'b0;
    tick();
    tick();
    total++; if ({pend1, sched_busy, adc1_start_trigger} !== 3'b100) begin bad++; $display("FAIL enable_hold: pend1/busy/trig1 got %b expected 100", {pend1, sched_busy, adc1_start_trigger}); end
    en = 1'b1;
    tick();
    total++; if (adc1_start_trigger !== 1'b1) begin bad++; $display("FAIL enable_release: trig1 got %b expected 1", adc1_start_trigger); end
    wait_idle(200, "enable");
  endtask

  task automatic test_round_robin();
    do_reset();
    prio_mode = 1'b0; T_gap = 32'd2;
    for (int r = 0; r < 2; r++) begin
      req1 = 1'b1; req2 = 1'b1;
      tick();
      req1 = 1'b0; req2 = 1'b0;
      wait_idle(500, "rr");
    end
    total++; if (q2s() != "1 2 1 2 ") begin bad++; $display("FAIL rr_order: got '%s' expected '1 2 1 2 '", q2s()); end
    total++; if ({cnt1, cnt2} !== {16'd2, 16'd2}) begin bad++; $display("FAIL rr_counts: cnt1=%0d cnt2=%0d expected 2/2", cnt1, cnt2); end
  endtask

  task automatic test_fixed_priority();
    int sent = 0;
    int seen = 0;
    int cyc  = 0;
    do_reset();
    prio_mode = 1'b1; T_gap = 32'd1; e2_len = 8;
    req1 = 1'b1; req2 = 1'b1;
    while (grants.size() < 4 && cyc < 1000) begin
      tick();
      cyc++;
      req1 = 1'b0; req2 = 1'b0;
      if (grants.size() > seen) begin
        seen = grants.size();
        if (grants[seen-1] == 2 && sent < 2) begin
          req2 = 1'b1;
          sent++;
        end
      end
    end
    req2 = 1'b0;
    wait_idle(500, "prio");
    total++; if (q2s() != "2 2 2 1 ") begin bad++; $display("FAIL prio_order: got '%s' expected '2 2 2 1 '", q2s()); end
    total++; if ({cnt1, cnt2} !== {16'd1, 16'd3}) begin bad++; $display("FAIL prio_counts: cnt1=%0d cnt2=%0d expected 1/3", cnt1, cnt2); end
    prio_mode = 1'b0; e2_len = 5;
  endtask

  task automatic test_timeout();
    do_reset();
    eng2_on = 1'b0; T_gap = 32'd5;
    req2 = 1'b1;
    tick();
    req2 = 1'b0;
    tick();
    total++; if ({adc2_start_trigger, active_sel} !== 3'b110) begin bad++; $display("FAIL to_grant: trig2/sel got %b expected 110", {adc2_start_trigger, active_sel}); end
    repeat (63) tick();
    total++; if ({err_timeout, sched_busy} !== 2'b01) begin bad++; $display("FAIL to_early: err/busy got %b expected 01", {err_timeout, sched_busy}); end
    tick();
    total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL to_flag: got %b expected 1", err_timeout); end
    total++; if (cnt2 !== 16'd0) begin bad++; $display("FAIL to_cnt2: got %0d expected 0", cnt2); end
    repeat (4) tick();
    total++; if (sched_busy !== 1'b1) begin bad++; $display("FAIL to_gap: sched_busy got %b expected 1", sched_busy); end
    tick();
    total++; if ({sched_busy, active_sel} !== 3'b000) begin bad++; $display("FAIL to_idle: busy/sel got %b expected 000", {sched_busy, active_sel}); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL to_clear: got %b expected 0", err_timeout); end
    eng2_on = 1'b1;
  endtask

  task automatic test_ovf_conflict();
    do_reset();
    T_gap = 32'd2; e2_len = 30;
    req2 = 1'b1;
    tick();
    req2 = 1'b0;
    tick();
    repeat (4) tick();
    req1 = 1'b1;
    tick();
    req1 = 1'b0;
    total++; if ({pend1, err_ovf} !== 2'b10) begin bad++; $display("FAIL ovf_first: pend1/ovf got %b expected 10", {pend1, err_ovf}); end
    req1 = 1'b1;
    tick();
    req1 = 1'b0;
    total++; if ({pend1, err_ovf} !== 2'b11) begin bad++; $display("FAIL ovf_second: pend1/ovf got %b expected 11", {pend1, err_ovf}); end
    total++; if (err_conflict !== 1'b0) begin bad++; $display("FAIL conflict_pre: got %b expected 0", err_conflict); end
    busy1_force = 1'b1;
    tick();
    busy1_force = 1'b0;
    tick();
    total++; if (err_conflict !== 1'b1) begin bad++; $display("FAIL conflict_set: got %b expected 1", err_conflict); end
    clr_err = 1'b1; busy1_force = 1'b1;
    tick();
    clr_err = 1'b0; busy1_force = 1'b0;
    total++; if ({err_conflict, err_ovf} !== 2'b10) begin bad++; $display("FAIL clr_vs_event: conflict/ovf got %b expected 10", {err_conflict, err_ovf}); end
    wait_idle(500, "ovf");
    total++; if (q2s() != "2 1 ") begin bad++; $display("FAIL ovf_order: got '%s' expected '2 1 '", q2s()); end
    total++; if ({cnt1, cnt2} !== {16'd1, 16'd1}) begin bad++; $display("FAIL ovf_counts: cnt1=%0d cnt2=%0d expected 1/1", cnt1, cnt2); end
    e2_len = 5;
  endtask

  task automatic test_reset_mid();
    eng1_on = 1'b0;
    req1 = 1'b1;
    tick();
    req1 = 1'b0; req2 = 1'b1;
    tick();
    req2 = 1'b0;
    total++; if ({adc1_start_trigger, pend2} !== 2'b11) begin bad++; $display("FAIL mid_pre: trig1/pend2 got %b expected 11", {adc1_start_trigger, pend2}); end
    rst_n = 1'b0;
    tick();
    total++; if ({adc1_start_trigger, adc2_start_trigger, active_sel, sched_busy} !== 5'b0) begin bad++; $display("FAIL mid_ctrl: got %b expected 00000", {adc1_start_trigger, adc2_start_trigger, active_sel, sched_busy}); end
    total++; if ({pend1, pend2, cnt1, cnt2} !== 34'd0) begin bad++; $display("FAIL mid_state: pend=%b cnt1=%0d cnt2=%0d expected all 0", {pend1, pend2}, cnt1, cnt2); end
    total++; if ({err_timeout, err_conflict, err_ovf} !== 3'b000) begin bad++; $display("FAIL mid_err: got %b expected 000", {err_timeout, err_conflict, err_ovf}); end
    rst_n = 1'b1;
    eng1_on = 1'b1;
    req1 = 1'b1;
    tick();
    req1 = 1'b0;
    tick();
    total++; if ({adc1_start_trigger, active_sel} !== 3'b101) begin bad++; $display("FAIL mid_regrant: trig1/sel got %b expected 101", {adc1_start_trigger, active_sel}); end
    wait_idle(200, "mid");
    total++; if (cnt1 !== 16'd1) begin bad++; $display("FAIL mid_cnt1: got %0d expected 1", cnt1); end
  endtask

  task automatic test_invariants();
    total++; if (overlap_err !== 0) begin bad++; $display("FAIL overlap: %0d overlapping cycles, expected 0", overlap_err); end
    total++; if (len_err !== 0) begin bad++; $display("FAIL trig_len: %0d pulses of wrong width, expected 0", len_err); end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; prio_mode = 1'b0; T_gap = 32'd10;
    req1 = 1'b0; req2 = 1'b0; clr_err = 1'b0; busy1_force = 1'b0;
    test_reset();
    test_single();
    test_enable();
    test_round_robin();
    test_fixed_priority();
    test_timeout();
    test_ovf_conflict();
    test_reset_mid();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1ms, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/readout_arbiter.md
Name: readout_arbiter

Overview:
- Scheduler in front of the two readout engines (full-resolution ADC1 engine, 1-bit ADC2 engine). The two engines share one row decoder and one column/ADC pin set.
- Captures readout requests from the exposure controller and grants the shared readout path to one engine at a time.
- Issues each engine's start trigger, tracks its busy handshake, and enforces a guard gap between readouts.
- Flags protocol errors: start timeout, unexpected busy, request overflow.

Parameters:
- TRIG_LEN, 2, width in TX_CLK cycles of each start-trigger pulse (1..15).
- BUSY_TIMEOUT, 64, max cycles from trigger assertion to the granted engine's busy rising.
- CNT_W, 16, width of the completed-readout counters.

Ports:
- TX_CLK  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  1 = new grants allowed; 0 = finish the current readout, then hold.
- prio_mode  in  1  0 = round-robin; 1 = fixed priority to ADC2.
- T_gap  in  32  guard cycles after busy falls before the next grant.
- req1  in  1  1-cycle pulse requesting a full ADC1 readout.
- req2  in  1  1-cycle pulse requesting a 1-bit ADC2 readout.
- adc1_busy  in  1  busy from the ADC1 engine.
- adc2_busy  in  1  busy from the ADC2 engine.
- adc1_start_trigger  out  1  start pulse to the ADC1 engine.
- adc2_start_trigger  out  1  start pulse to the ADC2 engine.
- active_sel  out  2  00 none, 01 ADC1 granted, 10 ADC2 granted.
- sched_busy  out  1  high in every state except IDLE.
- pend1  out  1  pending ADC1 request flag.
- pend2  out  1  pending ADC2 request flag.
- cnt1  out  CNT_W  completed ADC1 readouts, wraps.
- cnt2  out  CNT_W  completed ADC2 readouts, wraps.
- clr_err  in  1  synchronous clear of all error flags.
- err_timeout  out  1  sticky: busy never rose within BUSY_TIMEOUT.
- err_conflict  out  1  sticky: busy seen on a non-granted engine.
- err_ovf  out  1  sticky: req arrived while the same pend flag was already set.

Behaviour:
- Reset (rst_n=0 at clock edge):
  - All outputs 0; state IDLE; pend flags, counters and error flags cleared; last-grant register = ADC2 (so the first round-robin tie goes to ADC1).
  - Reset mid-readout drops the trigger on the next edge. The engines themselves are not reset by this block.
- Request capture:
  - reqN sets pendN the following cycle.
  - reqN while pendN=1 sets err_ovf; the request is not queued twice.
  - A req arriving in the same cycle its pend flag is cleared by a grant re-sets pend (new request retained).
- States:
  - IDLE:
    - If en=1 and any pend is set, pick a winner and go to TRIG.
    - Winner with both pending: prio_mode=1 → ADC2; prio_mode=0 → the engine not granted last.
    - Clear the winner's pend flag; set active_sel.
  - TRIG:
    - Drive the winner's start trigger high for exactly TRIG_LEN cycles, starting the cycle after the grant.
    - The timeout counter starts with the first trigger cycle.
    - Go to WAIT_RISE after TRIG_LEN cycles; if the winner's busy is already high, go straight to WAIT_FALL.
  - WAIT_RISE:
    - Winner busy=1 → WAIT_FALL.
    - Timeout counter reaching BUSY_TIMEOUT → set err_timeout, go to GAP; no count increment.
  - WAIT_FALL:
    - Winner busy=0 → increment cntN (wraps to 0 from all-ones), go to GAP.
    - No timeout in this state (readout length depends on the engine configuration).
  - GAP:
    - Count T_gap cycles, then go to IDLE and set active_sel=00.
    - T_gap=0 → return to IDLE on the next cycle.
- Grant latency: from a req pulse in IDLE (en=1), the trigger rises 2 cycles later (1 cycle capture, 1 cycle grant).
- Conflict:
  - In any state, the non-granted engine's busy =1 sets err_conflict (in IDLE, either busy =1 counts).
  - Sequencing continues unaffected.
- Triggers are never asserted simultaneously; at most one engine is granted at any time.
- en=0 never aborts an in-flight readout; pend flags still accumulate while en=0.
- clr_err clears the error flags in that cycle; an error event in the same cycle wins, leaving the flag set.
- T_gap is sampled on entry to GAP; changes mid-GAP are ignored.

Test Plan:
- Single request: req1 pulse; adc1_busy rises 3 cycles after the trigger and stays high 100 cycles; T_gap=10 → adc1_start_trigger high exactly 2 cycles, starting 2 cycles after req1; cnt1=1; sched_busy falls 11 cycles after busy falls; adc2_start_trigger never asserted.
- Round-robin: prio_mode=0, req1 and req2 in the same cycle, twice → grant order ADC1, ADC2, ADC1, ADC2; cnt1=2, cnt2=2; no overlap of active_sel.
- Fixed priority: prio_mode=1, both pending, followed by a further req2 during each ADC2 readout → ADC2 granted repeatedly; ADC1 granted only once pend2=0.
- Timeout: req2 with adc2_busy held 0 → err_timeout set 64 cycles after trigger start; cnt2 unchanged; return to IDLE after T_gap; clr_err clears the flag.
- Overflow and conflict: two req1 pulses while ADC2 is busy → err_ovf=1 and only one ADC1 readout follows; adc1_busy forced high during the ADC2 grant → err_conflict=1.
- Reset mid-readout: rst_n low for 1 cycle during TRIG → trigger 0 next cycle; all counters, flags and pend flags 0; a fresh req1 is then served normally.
